config_chain_writer: RTL and testbench

Serial programmer for the configuration shift-register chains of the neural array. Accepts parallel configuration words over a valid/ready handshake and shifts them MSB-first onto one of `NUM_CHAINS` chain inputs, driving each chain's `data_in`/`data_clk` pair. It also captures the bits shifted out of the chain's far end, giving loopback readback and verification. It is the master end of the chains the array exposes as `cfg_in`, one chain per synapse row plus one neuron chain.

---
 rtl/config_chain_writer.sv | 158 +++++++++++++++
 tb/tb_config_chain_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_writer.sv
// Serial master for the neural array configuration chains: one parallel word in, MSB-first bit stream out.
// Latency 2*WORD_WIDTH*HALF_PERIOD+1 cycles from acceptance to done; wr_ready stays low until the word completes.
module config_chain_writer #(
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_CHAINS  = 2,
    parameter int HALF_PERIOD = 2,
    parameter int SEL_W       = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0]      wr_chain,
    output logic [NUM_CHAINS-1:0] cfg_data_in,
    output logic [NUM_CHAINS-1:0] cfg_data_clk,
    input  logic [NUM_CHAINS-1:0] cfg_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] rd_data
);

    localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [SEL_W:0]  NC_L      = (SEL_W+1)'(NUM_CHAINS);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [PH_W-1:0]       phase_q, phase_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [WORD_WIDTH-1:0] shift_q, shift_n;
    logic [WORD_WIDTH-1:0] rd_q, rd_n;
    logic [SEL_W-1:0]      sel_q, sel_n;
    logic                  err_q, err_n;
    logic [NUM_CHAINS-1:0] pin_din_q, pin_din_n;
    logic [NUM_CHAINS-1:0] pin_clk_q, pin_clk_n;
    logic                  chain_bad;
    logic                  fb_bit;
    logic                  active_n;

    assign chain_bad = ({1'b0, wr_chain} >= NC_L);

    // Far-end bit of the currently latched chain.
    always_comb begin
        fb_bit = 1'b0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (sel_q == SEL_W'(c)) begin
                fb_bit = cfg_data_out[c];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        rd_n    = rd_q;
        sel_n   = sel_q;
        err_n   = err_q;
        case (state_q)
            S_IDLE: begin
                if (wr_valid) begin
                    shift_n = wr_data;
                    sel_n   = wr_chain;
                    bit_n   = BIT_LAST;
                    phase_n = '0;
                    rd_n    = '0;
                    err_n   = chain_bad;
                    state_n = chain_bad ? S_FIN : S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == PH_LAST) begin
                    phase_n = '0;
                    // Sampled before the rising edge, so this is the chain's old content.
                    rd_n    = {rd_q[WORD_WIDTH-2:0], fb_bit};
                    state_n = S_HIGH;
                end else begin
                    phase_n = phase_q + PH_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_n = '0;
                    if (bit_q == '0) begin
                        state_n = S_FIN;
                    end else begin
                        bit_n   = bit_q - BIT_W'(1);
                        shift_n = shift_q << 1;
                        state_n = S_SETUP;
                    end
                end else begin
                    phase_n = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Pins are registered from next-state values so they line up with the state they belong to.
    assign active_n = (state_n == S_SETUP) || (state_n == S_HIGH);

    always_comb begin
        pin_din_n = '0;
        pin_clk_n = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (sel_n == SEL_W'(c)) begin
                pin_din_n[c] = active_n && shift_n[WORD_WIDTH-1];
                pin_clk_n[c] = (state_n == S_HIGH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rd_q      <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            pin_din_q <= '0;
            pin_clk_q <= '0;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            rd_q      <= rd_n;
            sel_q     <= sel_n;
            err_q     <= err_n;
            pin_din_q <= pin_din_n;
            pin_clk_q <= pin_clk_n;
        end
    end

    assign wr_ready     = (state_q == S_IDLE);
    assign busy         = (state_q == S_SETUP) || (state_q == S_HIGH);
    assign done         = (state_q == S_FIN);
    assign err          = (state_q == S_FIN) && err_q;
    assign rd_data      = rd_q;
    assign cfg_data_in  = pin_din_q;
    assign cfg_data_clk = pin_clk_q;

endmodule

// File: tb/tb_config_chain_writer.sv
// Bench for config_chain_writer: two instances (HALF_PERIOD 2 and 1, three chains each) driving behavioural chain models.
module tb_config_chain_writer;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        vld  [2];
    logic        rdy  [2];
    logic [15:0] dat  [2];
    logic [1:0]  chn  [2];
    logic [2:0]  din  [2];
    logic [2:0]  cko  [2];
    logic [2:0]  dout [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic        er   [2];
    logic [15:0] rdd  [2];

    // Behavioural 16-bit chains; far end is the MSB.
    logic [15:0] chain_m [2][3];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          acc_q[$];
    int          done_q[$];
    logic [15:0] rd_q[$];
    logic        err_q[$];
    logic        bitq[$];
    int          edges[3];
    int          busy_bad, pin_bad, hold_bad;
    logic [2:0]  prev_clk, prev_din;
    logic [1:0]  cur_ch;
    bit          inflight;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        for (genvar gc = 0; gc < 3; gc++) begin : g_ch
            assign dout[gi][gc] = chain_m[gi][gc][15];
        end
    end

    config_chain_writer #(.WORD_WIDTH(16), .NUM_CHAINS(3), .HALF_PERIOD(2)) u_dut (
        .clk(clk), .reset(rst[0]), .wr_valid(vld[0]), .wr_ready(rdy[0]), .wr_data(dat[0]),
        .wr_chain(chn[0]), .cfg_data_in(din[0]), .cfg_data_clk(cko[0]), .cfg_data_out(dout[0]),
        .busy(bsy[0]), .done(dn[0]), .err(er[0]), .rd_data(rdd[0]));

    config_chain_writer #(.WORD_WIDTH(16), .NUM_CHAINS(3), .HALF_PERIOD(1)) u_dut_hp1 (
        .clk(clk), .reset(rst[1]), .wr_valid(vld[1]), .wr_ready(rdy[1]), .wr_data(dat[1]),
        .wr_chain(chn[1]), .cfg_data_in(din[1]), .cfg_data_clk(cko[1]), .cfg_data_out(dout[1]),
        .busy(bsy[1]), .done(dn[1]), .err(er[1]), .rd_data(rdd[1]));

    function automatic int word_cycles(input int i, input logic [1:0] ch);
        int hp;
        hp = (i == 0) ? 2 : 1;
        return (ch == 2'd3) ? 1 : 2 * 16 * hp + 1;
    endfunction

    function automatic logic [15:0] bits_word();
        logic [15:0] w;
        w = '0;
        foreach (bitq[k]) w = {w[14:0], bitq[k]};
        return w;
    endfunction

    task automatic clear_obs();
        cyc = 0;
        acc_q.delete(); done_q.delete(); rd_q.delete(); err_q.delete(); bitq.delete();
        for (int c = 0; c < 3; c++) edges[c] = 0;
        busy_bad = 0; pin_bad = 0; hold_bad = 0;
        prev_clk = '0; prev_din = '0; inflight = 0; cur_ch = '0;
    endtask

    // Observe the current cycle of instance i (called at a negedge), then advance one cycle.
    task automatic step(input int i);
        logic [2:0] one, mask;
        one = 3'b001;
        cyc++;
        for (int c = 0; c < 3; c++) begin
            if (cko[i][c] && !prev_clk[c]) begin
                edges[c]++;
                bitq.push_back(din[i][c]);
                chain_m[i][c] = {chain_m[i][c][14:0], din[i][c]};
            end
            if (cko[i][c] && din[i][c] !== prev_din[c]) hold_bad++;
        end
        if (bsy[i] !== (inflight && !dn[i])) busy_bad++;
        mask = bsy[i] ? (one << cur_ch) : 3'b000;
        if (((cko[i] | din[i]) & ~mask) !== 3'b000) pin_bad++;
        if (dn[i] === 1'b1) begin
            done_q.push_back(cyc); rd_q.push_back(rdd[i]); err_q.push_back(er[i]);
            inflight = 0;
        end
        if (vld[i] && rdy[i] && !rst[i]) begin
            acc_q.push_back(cyc); inflight = 1; cur_ch = chn[i];
        end
        prev_clk = cko[i];
        prev_din = din[i];
        @(negedge clk);
    endtask

    task automatic do_write(input int i, input logic [15:0] d, input logic [1:0] ch, output bit to);
        int n0, a0;
        n0 = done_q.size(); a0 = acc_q.size();
        vld[i] = 1'b1; dat[i] = d; chn[i] = ch;
        to = 1;
        for (int k = 0; k < 10; k++) begin
            step(i);
            if (acc_q.size() > a0) begin to = 0; break; end
        end
        vld[i] = 1'b0;
        if (!to) begin
            to = 1;
            for (int k = 0; k < 200; k++) begin
                step(i);
                if (done_q.size() > n0) begin to = 0; break; end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; dat[i] = '0; chn[i] = '0;
        end
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({rdy[i], bsy[i], dn[i], er[i]} !== 4'b1000) begin
                n_fail++; $display("FAIL reset_ctrl[%0d]: got %b expected 1000", i, {rdy[i], bsy[i], dn[i], er[i]});
            end
            n_checks++;
            if (rdd[i] !== 16'h0) begin
                n_fail++; $display("FAIL reset_rd[%0d]: got %h expected 0000", i, rdd[i]);
            end
            n_checks++;
            if ({cko[i], din[i]} !== 6'b0) begin
                n_fail++; $display("FAIL reset_pins[%0d]: got %b expected 000000", i, {cko[i], din[i]});
            end
            rst[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        bit to;
        logic [15:0] pre;
        pre = chain_m[0][0];
        clear_obs();
        do_write(0, 16'hA5C3, 2'd0, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected done"); end
        n_checks++;
        if (done_q[$] - acc_q[0] !== 65) begin
            n_fail++; $display("FAIL single_done_cycle: got %0d expected 65", done_q[$] - acc_q[0]);
        end
        n_checks++;
        if (edges[0] !== 16 || bits_word() !== 16'hA5C3) begin
            n_fail++; $display("FAIL single_bits: got %0d edges word %h expected 16 edges word a5c3", edges[0], bits_word());
        end
        n_checks++;
        if (edges[1] !== 0 || edges[2] !== 0 || pin_bad !== 0) begin
            n_fail++; $display("FAIL single_other_chains: got edges %0d/%0d pin_bad %0d expected 0", edges[1], edges[2], pin_bad);
        end
        n_checks++;
        if (rd_q[$] !== pre || err_q[$] !== 1'b0) begin
            n_fail++; $display("FAIL single_rd: got %h err %b expected %h err 0", rd_q[$], err_q[$], pre);
        end
        n_checks++;
        if (busy_bad !== 0 || hold_bad !== 0) begin
            n_fail++; $display("FAIL single_busy_hold: got busy_bad %0d hold_bad %0d expected 0", busy_bad, hold_bad);
        end
    endtask

    task automatic test_loopback();
        bit to;
        chain_m[0][1] = 16'h1234;
        clear_obs();
        do_write(0, 16'hBEEF, 2'd1, to);
        n_checks++;
        if (to || rd_q[$] !== 16'h1234) begin
            n_fail++; $display("FAIL loop_rd1: got %h timeout %b expected 1234", rd_q[$], to);
        end
        n_checks++;
        if (chain_m[0][1] !== 16'hBEEF) begin
            n_fail++; $display("FAIL loop_chain: got %h expected beef", chain_m[0][1]);
        end
        clear_obs();
        do_write(0, 16'h0000, 2'd1, to);
        n_checks++;
        if (to || rd_q[$] !== 16'hBEEF) begin
            n_fail++; $display("FAIL loop_rd2: got %h timeout %b expected beef", rd_q[$], to);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ch;
        logic [15:0] pre;
        ch = 2'($urandom_range(0, 2));
        pre = chain_m[0][ch];
        clear_obs();
        vld[0] = 1'b1; dat[0] = 16'hFFFF; chn[0] = ch;
        for (int k = 0; k < 200 && done_q.size() < 1; k++) step(0);
        dat[0] = 16'h0001;
        for (int k = 0; k < 10 && acc_q.size() < 2; k++) step(0);
        vld[0] = 1'b0;
        for (int k = 0; k < 200 && done_q.size() < 2; k++) step(0);
        n_checks++;
        if (done_q.size() !== 2 || acc_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d acc %0d done expected 2 2", acc_q.size(), done_q.size());
        end
        n_checks++;
        if (acc_q[$] - done_q[0] !== 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d expected 1", acc_q[$] - done_q[0]);
        end
        n_checks++;
        if (done_q[$] - acc_q[$] !== 65) begin
            n_fail++; $display("FAIL b2b_done2: got %0d expected 65", done_q[$] - acc_q[$]);
        end
        n_checks++;
        if (bitq.size() !== 32 || edges[ch] !== 32 || chain_m[0][ch] !== 16'h0001) begin
            n_fail++; $display("FAIL b2b_edges: got %0d edges chain %h expected 32 0001", edges[ch], chain_m[0][ch]);
        end
        n_checks++;
        if (rd_q[0] !== pre || rd_q[$] !== 16'hFFFF) begin
            n_fail++; $display("FAIL b2b_rd: got %h %h expected %h ffff", rd_q[0], rd_q[$], pre);
        end
    endtask

    task automatic test_out_of_range();
        bit to;
        logic [15:0] snap [3];
        for (int c = 0; c < 3; c++) snap[c] = chain_m[0][c];
        clear_obs();
        do_write(0, 16'h5A5A, 2'd3, to);
        n_checks++;
        if (to || done_q[$] - acc_q[0] !== 1) begin
            n_fail++; $display("FAIL oor_done_cycle: got %0d timeout %b expected 1", done_q[$] - acc_q[0], to);
        end
        n_checks++;
        if (err_q[$] !== 1'b1 || rd_q[$] !== 16'h0) begin
            n_fail++; $display("FAIL oor_err_rd: got err %b rd %h expected 1 0000", err_q[$], rd_q[$]);
        end
        n_checks++;
        if (bitq.size() !== 0 || pin_bad !== 0 || busy_bad !== 0) begin
            n_fail++; $display("FAIL oor_pins: got edges %0d pin_bad %0d busy_bad %0d expected 0", bitq.size(), pin_bad, busy_bad);
        end
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL oor_ready: got %b expected 1", rdy[0]);
        end
        n_checks++;
        if (chain_m[0][0] !== snap[0] || chain_m[0][1] !== snap[1] || chain_m[0][2] !== snap[2]) begin
            n_fail++; $display("FAIL oor_chains: got modified chain expected untouched");
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [1:0] ch;
        logic [15:0] pre;
        ch = 2'($urandom_range(0, 2));
        clear_obs();
        vld[0] = 1'b1; dat[0] = 16'h8001; chn[0] = ch;
        for (int k = 0; k < 10 && acc_q.size() < 1; k++) step(0);
        vld[0] = 1'b0;
        for (int k = 0; k < 100 && edges[ch] < 5; k++) step(0);
        rst[0] = 1'b1; vld[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cko[0], din[0]} !== 6'b0 || dn[0] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pins: got pins %b done %b expected 0", {cko[0], din[0]}, dn[0]);
        end
        n_checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || done_q.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_state: got ready %b busy %b dones %0d expected 1 0 0", rdy[0], bsy[0], done_q.size());
        end
        rst[0] = 1'b0; vld[0] = 1'b0;
        n_checks++;
        if (edges[ch] !== 5 || chain_m[0][ch][4:0] !== 5'b10000) begin
            n_fail++; $display("FAIL rstmid_partial: got %0d edges low bits %b expected 5 10000", edges[ch], chain_m[0][ch][4:0]);
        end
        pre = chain_m[0][ch];
        clear_obs();
        step(0);
        do_write(0, 16'h00FF, ch, to);
        n_checks++;
        if (to || edges[ch] !== 16 || bits_word() !== 16'h00FF || rd_q[$] !== pre) begin
            n_fail++; $display("FAIL rstmid_rewrite: got %0d edges word %h rd %h expected 16 00ff %h", edges[ch], bits_word(), rd_q[$], pre);
        end
    endtask

    task automatic test_hp1();
        bit to;
        logic [15:0] d, pre;
        d = 16'($urandom);
        pre = chain_m[1][2];
        clear_obs();
        do_write(1, d, 2'd2, to);
        n_checks++;
        if (to || done_q[$] - acc_q[0] !== 33) begin
            n_fail++; $display("FAIL hp1_done_cycle: got %0d timeout %b expected 33", done_q[$] - acc_q[0], to);
        end
        n_checks++;
        if (edges[2] !== 16 || bits_word() !== d || rd_q[$] !== pre) begin
            n_fail++; $display("FAIL hp1_data: got %0d edges word %h rd %h expected 16 %h %h", edges[2], bits_word(), rd_q[$], d, pre);
        end
        n_checks++;
        if (busy_bad !== 0 || pin_bad !== 0 || hold_bad !== 0) begin
            n_fail++; $display("FAIL hp1_pins: got %0d/%0d/%0d expected 0/0/0", busy_bad, pin_bad, hold_bad);
        end
    endtask

    task automatic test_random();
        bit to;
        int i, exp_edges;
        logic [1:0] ch;
        logic [15:0] d, exp_rd;
        for (int n = 0; n < 16; n++) begin
            i = int'($urandom_range(0, 1));
            ch = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            if (ch != 2'd3) chain_m[i][ch] = 16'($urandom);
            exp_rd = (ch == 2'd3) ? 16'h0 : chain_m[i][ch];
            exp_edges = (ch == 2'd3) ? 0 : 16;
            clear_obs();
            do_write(i, d, ch, to);
            n_checks++;
            if (to || done_q[$] - acc_q[0] !== word_cycles(i, ch)) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, done_q[$] - acc_q[0], word_cycles(i, ch));
            end
            n_checks++;
            if (err_q[$] !== (ch == 2'd3) || rd_q[$] !== exp_rd) begin
                n_fail++; $display("FAIL rand_result[%0d]: got err %b rd %h expected %b %h", n, err_q[$], rd_q[$], ch == 2'd3, exp_rd);
            end
            n_checks++;
            if (bitq.size() !== exp_edges || (exp_edges == 16 && bits_word() !== d)) begin
                n_fail++; $display("FAIL rand_bits[%0d]: got %0d edges word %h expected %0d %h", n, bitq.size(), bits_word(), exp_edges, d);
            end
            n_checks++;
            if (busy_bad + pin_bad + hold_bad !== 0) begin
                n_fail++; $display("FAIL rand_pins[%0d]: got %0d/%0d/%0d expected 0/0/0", n, busy_bad, pin_bad, hold_bad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) chain_m[i][c] = 16'($urandom);
        clear_obs();
        test_reset();
        test_single_word();
        test_loopback();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_hp1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
